// File: rtl/sram_pkg.sv
// Shared types and HM628128 geometry for the SRAM pin responder.
package sram_pkg;

  localparam int HM_ABITS = 17;
  localparam int HM_DBITS = 8;

  localparam int               PULSE_W   = 8;
  localparam logic [PULSE_W-1:0] PULSE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    READ_DRIVE,
    WRITE
  } resp_state_t;

endpackage

// File: rtl/sram_pin_sync.sv
// Multi-stage synchronizer over a bus of asynchronous pins; every bit sees the same
// depth so the bits leave the pipeline mutually aligned. SYNC must be at least 2.
module sram_pin_sync #(
  parameter int W    = 1,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_rst_val,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [SYNC-1:0][W-1:0] r_stage;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // value its predecessor held before the edge, giving a true shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= {SYNC{i_rst_val}};
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[SYNC-1];

endmodule

// File: rtl/sram_responder.sv
// HM628128-style asynchronous SRAM responder backed by on-chip storage, with
// cycle-counted access/write-pulse timing and sticky protocol error flags.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ABITS     = HM_ABITS,
  parameter int MEM_ABITS = 8,
  parameter int SYNC      = 2,
  parameter int ACC_CYC   = 1,
  parameter int WP_CYC    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ABITS-1:0]    sram_addr,
  input  logic [HM_DBITS-1:0] sram_dq_in,
  output logic [HM_DBITS-1:0] sram_dq_out,
  output logic                sram_dq_oe,
  input  logic                sram_we_,
  input  logic                sram_oe_,
  output logic [15:0]         wr_count,
  output logic [15:0]         rd_count,
  output logic                err_wp,
  output logic                err_contention,
  output logic                err_addr_wr
);

  localparam int SW    = ABITS + HM_DBITS + 2;
  localparam int ACC_W = (ACC_CYC < 2) ? 1 : $clog2(ACC_CYC + 1);

  // Synchronized pin view
  logic [SW-1:0]       w_sync_in;
  logic [SW-1:0]       w_sync_out;
  logic [SW-1:0]       w_sync_rst;
  logic [ABITS-1:0]    w_s_addr;
  logic [HM_DBITS-1:0] w_s_dq;
  logic                w_s_we_n;
  logic                w_s_oe_n;

  assign w_sync_in  = {sram_addr, sram_dq_in, sram_we_, sram_oe_};
  assign w_sync_rst = {{(ABITS + HM_DBITS){1'b0}}, 2'b11};

  sram_pin_sync #(
    .W    (SW),
    .SYNC (SYNC)
  ) u_pin_sync (
    .clk       (clk),
    .rst       (rst),
    .i_rst_val (w_sync_rst),
    .i_d       (w_sync_in),
    .o_q       (w_sync_out)
  );

  assign {w_s_addr, w_s_dq, w_s_we_n, w_s_oe_n} = w_sync_out;

  // State and datapath registers
  resp_state_t r_state;
  resp_state_t w_state_nxt;

  logic [ABITS-1:0]    r_wa;
  logic [ABITS-1:0]    r_ra;
  logic [PULSE_W-1:0]  r_pulse;
  logic [HM_DBITS-1:0] r_last_dq;
  logic [ACC_W-1:0]    r_acc;
  logic [HM_DBITS-1:0] r_dq_out;
  logic                r_dq_oe;
  logic [15:0]         r_wr_cnt;
  logic [15:0]         r_rd_cnt;
  logic                r_err_wp;
  logic                r_err_cont;
  logic                r_err_addr;

  logic [HM_DBITS-1:0] r_mem [2**MEM_ABITS];
  logic [HM_DBITS-1:0] w_rd_data;

  // FSM strobes
  logic w_wr_start;
  logic w_wr_hold;
  logic w_commit;
  logic w_err_wp_set;
  logic w_err_addr_set;
  logic w_err_cont_set;
  logic w_acc_clr;
  logic w_acc_inc;
  logic w_drive;
  logic w_undrive;
  logic w_acc_done;
  logic w_pulse_ok;

  assign w_acc_done = (r_acc == ACC_W'(ACC_CYC));
  assign w_pulse_ok = (r_pulse >= PULSE_W'(WP_CYC));
  assign w_rd_data  = r_mem[w_s_addr[MEM_ABITS-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_start     = 1'b0;
    w_wr_hold      = 1'b0;
    w_commit       = 1'b0;
    w_err_wp_set   = 1'b0;
    w_err_addr_set = 1'b0;
    w_err_cont_set = 1'b0;
    w_acc_clr      = 1'b0;
    w_acc_inc      = 1'b0;
    w_drive        = 1'b0;
    w_undrive      = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_s_we_n) begin
          w_state_nxt = WRITE;
          w_wr_start  = 1'b1;
        end else if (!w_s_oe_n) begin
          w_state_nxt = READ_WAIT;
          w_acc_clr   = 1'b1;
        end
      end

      READ_WAIT: begin
        if (!w_s_we_n) begin
          w_state_nxt = WRITE;
          w_wr_start  = 1'b1;
        end else if (w_s_oe_n) begin
          w_state_nxt = IDLE;
        end else if (w_acc_done) begin
          w_state_nxt = READ_DRIVE;
          w_drive     = 1'b1;
        end else begin
          w_acc_inc = 1'b1;
        end
      end

      READ_DRIVE: begin
        if (!w_s_we_n) begin
          w_state_nxt    = WRITE;
          w_wr_start     = 1'b1;
          w_undrive      = 1'b1;
          w_err_cont_set = 1'b1;
        end else if (w_s_oe_n) begin
          w_state_nxt = IDLE;
          w_undrive   = 1'b1;
        end else if (w_s_addr != r_ra) begin
          w_state_nxt = READ_WAIT;
          w_undrive   = 1'b1;
          w_acc_clr   = 1'b1;
        end
      end

      WRITE: begin
        if (!w_s_we_n) begin
          w_wr_hold      = 1'b1;
          w_err_addr_set = (w_s_addr != r_wa);
        end else begin
          w_commit     = w_pulse_ok;
          w_err_wp_set = !w_pulse_ok;
          if (!w_s_oe_n) begin
            w_state_nxt = READ_WAIT;
            w_acc_clr   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wa       <= '0;
      r_ra       <= '0;
      r_pulse    <= '0;
      r_last_dq  <= '0;
      r_acc      <= '0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_err_wp   <= 1'b0;
      r_err_cont <= 1'b0;
      r_err_addr <= 1'b0;
    end else begin
      // The commit uses the data seen on the last synchronized we_-low cycle.
      if (w_wr_start) begin
        r_wa      <= w_s_addr;
        r_pulse   <= PULSE_W'(1);
        r_last_dq <= w_s_dq;
      end else if (w_wr_hold) begin
        r_last_dq <= w_s_dq;
        if (r_pulse != PULSE_MAX) begin
          r_pulse <= r_pulse + 1'b1;
        end
      end

      if (w_acc_clr) begin
        r_acc <= '0;
      end else if (w_acc_inc) begin
        r_acc <= r_acc + 1'b1;
      end

      if (w_drive) begin
        r_dq_out <= w_rd_data;
        r_dq_oe  <= 1'b1;
        r_ra     <= w_s_addr;
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end else if (w_undrive) begin
        r_dq_oe <= 1'b0;
      end

      if (w_commit) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end

      if (w_err_wp_set)   r_err_wp   <= 1'b1;
      if (w_err_cont_set) r_err_cont <= 1'b1;
      if (w_err_addr_set) r_err_addr <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately left without reset so it maps onto
  // RAM primitives; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_wa[MEM_ABITS-1:0]] <= r_last_dq;
    end
  end

  // Gating with the synchronized we_ keeps the pad released in the very cycle the
  // initiator's write becomes visible, ahead of the registered release.
  assign sram_dq_out    = r_dq_out;
  assign sram_dq_oe     = r_dq_oe & w_s_we_n;
  assign wr_count       = r_wr_cnt;
  assign rd_count       = r_rd_cnt;
  assign err_wp         = r_err_wp;
  assign err_contention = r_err_cont;
  assign err_addr_wr    = r_err_addr;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: timing of reads/writes, error flags, aliasing,
// reset behaviour and a linked-list pointer chase over the whole storage.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] sram_addr;
  logic [7:0]  sram_dq_in;
  logic [7:0]  sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_;
  logic        sram_oe_;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic        err_wp;
  logic        err_contention;
  logic        err_addr_wr;

  int checks   = 0;
  int failures = 0;

  logic [16:0] chase_addr;
  logic [7:0]  chase_exp;

  always #5 clk = ~clk;

  sram_responder u_dut (
    .clk            (clk),
    .rst            (rst),
    .sram_addr      (sram_addr),
    .sram_dq_in     (sram_dq_in),
    .sram_dq_out    (sram_dq_out),
    .sram_dq_oe     (sram_dq_oe),
    .sram_we_       (sram_we_),
    .sram_oe_       (sram_oe_),
    .wr_count       (wr_count),
    .rd_count       (rd_count),
    .err_wp         (err_wp),
    .err_contention (err_contention),
    .err_addr_wr    (err_addr_wr)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [16:0] a, input logic [7:0] d, input int low);
    sram_addr  = a;
    sram_dq_in = d;
    sram_we_   = 1'b0;
    step(low);
    sram_we_ = 1'b1;
    step(4);
  endtask

  // Leaves the responder driving: dq valid from the 5th edge after oe_ falls.
  task automatic read_start(input logic [16:0] a);
    sram_addr = a;
    sram_oe_  = 1'b0;
    step(5);
  endtask

  task automatic read_end();
    sram_oe_ = 1'b1;
    step(3);
  endtask

  task automatic check_flags(input string tag, input logic wp, input logic cont, input logic aw);
    check({tag, "_err_wp"}, 32'(err_wp), 32'(wp));
    check({tag, "_err_cont"}, 32'(err_contention), 32'(cont));
    check({tag, "_err_addr"}, 32'(err_addr_wr), 32'(aw));
  endtask

  initial begin
    rst        = 1'b1;
    sram_addr  = '0;
    sram_dq_in = '0;
    sram_we_   = 1'b1;
    sram_oe_   = 1'b1;
    step(3);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    check("rst_dq_out", 32'(sram_dq_out), 32'h0);
    check("rst_wr_count", 32'(wr_count), 32'h0);
    check("rst_rd_count", 32'(rd_count), 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(2);

    // Basic write 0x5A -> 0x00010 with a 5-cycle pulse.
    do_write(17'h00010, 8'h5A, 5);
    check("wr1_count", 32'(wr_count), 32'd1);
    check_flags("wr1", 1'b0, 1'b0, 1'b0);

    // Read latency: oe_ sampled low at edge 0, dq driven from edge 4.
    sram_addr = 17'h00010;
    sram_oe_  = 1'b0;
    step(4);
    check("rd1_oe_edge3", 32'(sram_dq_oe), 32'h0);
    step(1);
    check("rd1_oe_edge4", 32'(sram_dq_oe), 32'h1);
    check("rd1_data", 32'(sram_dq_out), 32'h5A);
    check("rd1_count", 32'(rd_count), 32'd1);
    sram_oe_ = 1'b1;
    step(2);
    check("rd1_oe_hold", 32'(sram_dq_oe), 32'h1);
    step(1);
    check("rd1_oe_release", 32'(sram_dq_oe), 32'h0);

    // Short pulse is rejected and flagged; prior content survives.
    do_write(17'h00020, 8'h11, 4);
    check("wr2_count", 32'(wr_count), 32'd2);
    do_write(17'h00020, 8'h33, 2);
    check("short_wr_count", 32'(wr_count), 32'd2);
    check_flags("short", 1'b1, 1'b0, 1'b0);
    read_start(17'h00020);
    check("short_rd_data", 32'(sram_dq_out), 32'h11);
    check("short_rd_count", 32'(rd_count), 32'd2);
    read_end();

    // Pulse exactly WP_CYC long commits; address change mid-drive re-reads.
    do_write(17'h00011, 8'h77, 3);
    check("wp_exact_count", 32'(wr_count), 32'd3);
    read_start(17'h00010);
    check("ach_first_data", 32'(sram_dq_out), 32'h5A);
    check("ach_first_count", 32'(rd_count), 32'd3);
    sram_addr = 17'h00011;
    step(2);
    check("ach_oe_still", 32'(sram_dq_oe), 32'h1);
    step(1);
    check("ach_oe_drop", 32'(sram_dq_oe), 32'h0);
    step(1);
    check("ach_oe_wait", 32'(sram_dq_oe), 32'h0);
    step(1);
    check("ach_oe_redrive", 32'(sram_dq_oe), 32'h1);
    check("ach_data", 32'(sram_dq_out), 32'h77);
    check("ach_count", 32'(rd_count), 32'd4);
    read_end();

    // we_ falling while driving: pad released within SYNC+1 edges, contention flagged.
    check("cont_pre", 32'(err_contention), 32'h0);
    read_start(17'h00010);
    check("cont_rd_count", 32'(rd_count), 32'd5);
    sram_dq_in = 8'h5A;
    sram_we_   = 1'b0;
    step(3);
    check("cont_oe", 32'(sram_dq_oe), 32'h0);
    check("cont_flag", 32'(err_contention), 32'h1);
    step(2);
    sram_we_ = 1'b1;
    step(5);
    check("cont_wr_count", 32'(wr_count), 32'd4);
    check("cont_redrive_oe", 32'(sram_dq_oe), 32'h1);
    check("cont_redrive_data", 32'(sram_dq_out), 32'h5A);
    check("cont_redrive_count", 32'(rd_count), 32'd6);
    read_end();

    // Upper address bits alias onto the same storage.
    do_write(17'h10010, 8'hC3, 4);
    check("alias_wr_count", 32'(wr_count), 32'd5);
    read_start(17'h00010);
    check("alias_data", 32'(sram_dq_out), 32'hC3);
    read_end();

    // Address change during a write pulse: flagged, data lands at the original address.
    check("awr_pre", 32'(err_addr_wr), 32'h0);
    do_write(17'h00031, 8'h44, 4);
    sram_addr  = 17'h00030;
    sram_dq_in = 8'h99;
    sram_we_   = 1'b0;
    step(2);
    sram_addr = 17'h00031;
    step(3);
    sram_we_ = 1'b1;
    step(4);
    check("awr_wr_count", 32'(wr_count), 32'd7);
    check_flags("awr", 1'b1, 1'b1, 1'b1);
    read_start(17'h00030);
    check("awr_orig_data", 32'(sram_dq_out), 32'h99);
    read_end();
    read_start(17'h00031);
    check("awr_other_data", 32'(sram_dq_out), 32'h44);
    read_end();
    check("mid_rd_count", 32'(rd_count), 32'd9);

    // Reset mid-read drops the pad without waiting for a clock edge.
    do_write(17'h00040, 8'h12, 4);
    check("pre_rst_wr_count", 32'(wr_count), 32'd8);
    read_start(17'h00040);
    check("pre_rst_data", 32'(sram_dq_out), 32'h12);
    check("pre_rst_oe", 32'(sram_dq_oe), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_async_oe", 32'(sram_dq_oe), 32'h0);
    sram_oe_ = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
    check("post_rst_wr", 32'(wr_count), 32'h0);
    check("post_rst_rd", 32'(rd_count), 32'h0);
    check_flags("post_rst", 1'b0, 1'b0, 1'b0);

    // Reset mid-write: nothing is committed, storage keeps the old byte.
    sram_addr  = 17'h00040;
    sram_dq_in = 8'hEE;
    sram_we_   = 1'b0;
    step(3);
    rst      = 1'b1;
    sram_we_ = 1'b1;
    step(2);
    rst = 1'b0;
    step(4);
    check("rstwr_wr_count", 32'(wr_count), 32'h0);
    read_start(17'h00040);
    check("rstwr_data", 32'(sram_dq_out), 32'h12);
    read_end();

    // Linked list mem[i] = i+1 (mem[255] = 0), then a 300-hop pointer chase.
    for (int i = 0; i < 256; i++) begin
      do_write(17'(i), 8'((i + 1) % 256), 3);
    end
    check("ll_wr_count", 32'(wr_count), 32'd256);
    chase_addr = '0;
    for (int h = 0; h < 300; h++) begin
      chase_exp = 8'((h + 1) % 256);
      read_start(chase_addr);
      check("ll_hop", 32'(sram_dq_out), 32'(chase_exp));
      chase_addr = {9'b0, sram_dq_out};
      read_end();
    end
    check("ll_rd_count", 32'(rd_count), 32'd301);
    check_flags("ll", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
